// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry type for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int FQ_ADDR_W          = 32;
    localparam int FQ_DATA_W          = 32;
    localparam int FQ_DEPTH_DEFAULT   = 4;
    localparam int FQ_MAX_OUT_DEFAULT = 2;

    localparam logic RST_ENABLE_N = 1'b0;

    typedef struct packed {
        logic [FQ_ADDR_W-1:0] pc;
        logic [FQ_DATA_W-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO with extra-MSB pointers, occupancy count and a clear input.
module fq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE_N || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited ROM reads, in-order {pc, inst}
// delivery to decode, and flush/branch redirect that drops reads still in flight.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = FQ_ADDR_W,
    parameter int                DATA_W   = FQ_DATA_W,
    parameter int                DEPTH    = FQ_DEPTH_DEFAULT,
    parameter int                MAX_OUT  = FQ_MAX_OUT_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_req_o,
    output logic [ADDR_W-1:0]      rom_addr_o,
    input  logic                   rom_gnt_i,
    input  logic                   rom_rvalid_i,
    input  logic [DATA_W-1:0]      rom_rdata_i,
    input  logic                   flush_i,
    input  logic [ADDR_W-1:0]      new_pc_i,
    input  logic                   branch_i,
    input  logic [ADDR_W-1:0]      branch_target_i,
    output logic                   inst_valid_o,
    output logic [DATA_W-1:0]      inst_o,
    output logic [ADDR_W-1:0]      pc_o,
    input  logic                   inst_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credits_used;
    logic [ADDR_W-1:0] target;
    logic              redirect;
    logic              issue;
    logic              rsp;
    logic              push;
    logic              pop;
    logic              empty;
    entry_t            wr_entry;
    entry_t            rd_entry;

    assign redirect     = flush_i | branch_i;
    assign target       = flush_i ? new_pc_i : branch_target_i;
    assign credits_used = {1'b0, count} + {1'b0, outstanding};

    assign rom_req_o  = (rst != RST_ENABLE_N) && !redirect
                        && (credits_used < (CNT_W+1)'(DEPTH))
                        && (outstanding < CNT_W'(MAX_OUT));
    assign rom_addr_o = fetch_pc;
    assign issue      = rom_req_o && rom_gnt_i;

    // A response with nothing in flight (e.g. straight after reset) is stray and ignored.
    assign rsp  = rom_rvalid_i && (outstanding != '0);
    assign push = rsp && (discard == '0) && !redirect;
    assign pop  = inst_valid_o && inst_ready_i;

    assign wr_entry = '{pc: resp_pc, inst: rom_rdata_i};

    fq_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .empty (empty),
        .count (count)
    );

    assign inst_valid_o = !empty;
    assign inst_o       = empty ? '0 : rd_entry.inst;
    assign pc_o         = empty ? '0 : rd_entry.pc;
    assign count_o      = count;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE_N) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            // Dropped responses still return their credit when they arrive.
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp);
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= outstanding - CNT_W'(rsp);
            end else begin
                if (issue)                 fetch_pc <= fetch_pc + ADDR_W'(4);
                if (push)                  resp_pc  <= resp_pc + ADDR_W'(4);
                if (rsp && discard != '0)  discard  <= discard - CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction prefetch queue placed between the instruction ROM interface and if_id.
- Supersedes the single-cycle, lock-step pc_reg→rom→if_id fetch. Decouples fetch from decode stalls, supports multiple outstanding ROM reads with grant/valid handshake, and redirects on exception flush or branch.
- Delivers in-order {pc, inst} pairs to decode with a valid/ready handshake.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, queue entries (power of two, ≥2).
- MAX_OUT, 2, maximum outstanding ROM reads (1..DEPTH).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- rom_req_o  out  1  ROM read request.
- rom_addr_o  out  ADDR_W  ROM read address (word aligned).
- rom_gnt_i  in  1  ROM accepts request this cycle.
- rom_rvalid_i  in  1  read data valid; responses return in order.
- rom_rdata_i  in  DATA_W  read data.
- flush_i  in  1  exception flush from ctrl.
- new_pc_i  in  ADDR_W  exception handler / ERET target.
- branch_i  in  1  taken branch, asserted after the delay slot has been popped.
- branch_target_i  in  ADDR_W  branch target.
- inst_valid_o  out  1  head entry valid.
- inst_o  out  DATA_W  head instruction.
- pc_o  out  ADDR_W  head pc.
- inst_ready_i  in  1  decode accepts head (= !stall[1]).
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0 at edge):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - Queue empty; outstanding=0; discard=0.
  - Outputs: rom_req_o=0, rom_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0, count_o=0.
  - Reset mid-operation abandons all in-flight reads. Responses arriving in the first cycle after reset release are ignored.
- Request issue:
  - rom_req_o = !flush_i && !branch_i && (count + outstanding < DEPTH) && (outstanding < MAX_OUT). Uses registered count and outstanding.
  - rom_addr_o = fetch_pc.
  - Issue = rom_req_o && rom_gnt_i. On issue, fetch_pc += 4 and outstanding++.
  - Request held until granted; addr stable while rom_req_o=1 and not granted.
- Response:
  - On rom_rvalid_i: outstanding--.
  - If discard>0: drop the response and discard--.
  - Else push {resp_pc, rom_rdata_i} and resp_pc += 4.
  - Issue and response in the same cycle: outstanding unchanged.
- Pop:
  - inst_valid_o = !empty. inst_o/pc_o are driven from the head entry combinationally; they are 0 when empty.
  - Pop = inst_valid_o && inst_ready_i.
  - Push and pop in the same cycle leave count unchanged, including when the queue is full (a credit check guarantees push never overflows).
  - No bypass: a response is visible to decode the cycle after it is pushed. Minimum latency from rom_rvalid_i to inst_valid_o is 1 cycle.
- Redirect:
  - flush_i has priority over branch_i. Target is new_pc_i on flush, branch_target_i on branch.
  - Effect at the edge: queue cleared, count=0, fetch_pc=target, resp_pc=target.
  - discard = outstanding + (issue this cycle, always 0) − (rom_rvalid_i this cycle ? 1 : 0), i.e. every read in flight after the edge is dropped.
  - A pop in the redirect cycle is still accepted by decode (it was presented before the redirect), but the queue is cleared regardless.
  - rom_req_o=0 in the redirect cycle. Fetch from the target starts the next cycle.
  - A redirect while discard>0 accumulates: discard = old discard + newly outstanding reads.
  - Outstanding counter keeps counting dropped responses, so credits return only when dropped data actually arrives.
- Pointers: rd/wr pointers are $clog2(DEPTH)+1 bits. The MSB differs when full and matches when empty; wrap-around is natural modulo 2·DEPTH.
- Address arithmetic is modulo 2^ADDR_W; fetch_pc wraps silently at the top of address space.

Decomposition:
- Shared package / defines.v additions:
  - FQ_DEPTH_DEFAULT and FQ_MAX_OUT_DEFAULT constants.
  - Instruction-entry typedef {pc[ADDR_W-1:0], inst[DATA_W-1:0]}.
  - RstEnable_n = 1'b0 for active-low reset.
- One sub-module, fq_fifo: synchronous FIFO (storage, pointers, count, clear input) parametrised by width and depth.
- Top fetch_queue holds the pc registers, the outstanding and discard counters, and the request/redirect logic.

Test Plan:
- Straight-line fetch: ROM grants always, 1-cycle rvalid, inst_ready_i=1 → pc_o sequence 0x0,0x4,0x8,… with inst_valid_o=1 every cycle from cycle 3; outstanding never exceeds MAX_OUT=2.
- Decode stall: hold inst_ready_i=0 for 10 cycles → count_o saturates at 4; rom_req_o drops once count+outstanding=4; head stays pc 0x0; release → pcs 0x0..0xC popped in order, then 0x10.
- Flush with reads in flight: outstanding=2, flush_i=1, new_pc_i=0x0000_0180 → queue empty next cycle; next two rvalid responses dropped (inst_valid_o stays 0); first valid output pc_o=0x180.
- Branch and response in the same cycle: branch_i=1 with rom_rvalid_i=1, target 0x40, outstanding 2 → discard=1; one later response dropped; first delivered pc_o=0x40.
- Simultaneous flush_i and branch_i: new_pc_i=0x180, branch_target_i=0x40 → next fetch address 0x180.
- Reset mid-stream: rst=0 for one cycle with queue at 3 entries → all outputs return to reset values; after release rom_addr_o=RESET_PC and a stray rvalid in the first cycle is ignored.
